// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the MIPS
// memory-bus arbiter.
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RDATA,
    DONE
  } state_e;

  typedef enum logic {
    PORT_I,
    PORT_D
  } port_e;

  localparam logic [3:0]  BE_WORD      = 4'hF;
  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;

  function automatic port_e other_port(
    input port_e p
  );
    return (p == PORT_I) ? PORT_D : PORT_I;
  endfunction

endpackage

// File: rtl/mips_bus_rr_pick.sv
// Two-way round-robin choice between fetch
// and data requesters.
module mips_bus_rr_pick
  import mips_bus_pkg::*;
(
  input  logic  i_ireq,
  input  logic  i_dreq,
  input  port_e i_last,
  output logic  o_valid,
  output port_e o_pick
);

  // A tie goes to the port that did not win last.
  always_comb begin
    o_valid = i_ireq | i_dreq;
    o_pick  = PORT_I;
    unique case (1'b1)
      (i_ireq & i_dreq):
        o_pick = other_port(i_last);
      (!i_ireq & i_dreq):
        o_pick = PORT_D;
      default:
        o_pick = PORT_I;
    endcase
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// Shares one Avalon-style bus between fetch and
// data ports, one transaction at a time.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteenable,
  output logic [31:0] d_rdata,
  output logic        d_done,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  output logic        err,
  output logic        busy
);

  localparam bit LP_TO_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LP_TO_LAST =
    LP_TO_EN ? CNT_W'(TIMEOUT - 1) : '0;

  state_e           r_state;
  port_e            r_last;
  port_e            r_port;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_address;
  logic             r_read;
  logic             r_write;
  logic [31:0]      r_wdata;
  logic [3:0]       r_be;
  logic [31:0]      r_i_rdata;
  logic [31:0]      r_d_rdata;
  logic             r_i_done;
  logic             r_d_done;
  logic             r_err;
  logic             r_busy;

  logic             w_gnt;
  port_e            w_pick;

  mips_bus_rr_pick u_pick (
    .i_ireq  (i_req),
    .i_dreq  (d_req),
    .i_last  (r_last),
    .o_valid (w_gnt),
    .o_pick  (w_pick)
  );

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_last    <= PORT_D;
      r_port    <= PORT_I;
      r_cnt     <= '0;
      r_address <= '0;
      r_read    <= 1'b0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_be      <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
      r_i_done  <= 1'b0;
      r_d_done  <= 1'b0;
      r_err     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      r_err    <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_gnt) begin
            r_port  <= w_pick;
            r_last  <= w_pick;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= BUS;
            if (w_pick == PORT_I) begin
              r_address <= i_addr;
              r_read    <= 1'b1;
              r_write   <= 1'b0;
              r_wdata   <= '0;
              r_be      <= BE_WORD;
            end else begin
              r_address <= d_addr;
              r_read    <= !d_we;
              r_write   <= d_we;
              r_wdata   <= d_wdata;
              r_be      <= d_byteenable;
            end
          end
        end
        BUS: begin
          if (!waitrequest) begin
            r_address <= '0;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_be      <= '0;
            if (r_read) begin
              r_state <= RDATA;
            end else begin
              r_state  <= DONE;
              r_i_done <= (r_port == PORT_I);
              r_d_done <= (r_port == PORT_D);
            end
          end else if (LP_TO_EN &&
                       r_cnt == LP_TO_LAST) begin
            r_address <= '0;
            r_read    <= 1'b0;
            r_write   <= 1'b0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_err     <= 1'b1;
            r_state   <= DONE;
            r_i_done  <= (r_port == PORT_I);
            r_d_done  <= (r_port == PORT_D);
            if (r_read) begin
              if (r_port == PORT_I)
                r_i_rdata <= '0;
              else
                r_d_rdata <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RDATA: begin
          if (r_port == PORT_I)
            r_i_rdata <= readdata;
          else
            r_d_rdata <= readdata;
          r_i_done <= (r_port == PORT_I);
          r_d_done <= (r_port == PORT_D);
          r_state  <= DONE;
        end
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign address    = r_address;
  assign read       = r_read;
  assign write      = r_write;
  assign writedata  = r_wdata;
  assign byteenable = r_be;
  assign i_rdata    = r_i_rdata;
  assign d_rdata    = r_d_rdata;
  assign i_done     = r_i_done;
  assign d_done     = r_d_done;
  assign err        = r_err;
  assign busy       = r_busy;

endmodule

// File: doc/mips_bus_arbiter.md
Name: mips_bus_arbiter

Overview:
- Shares the single Avalon-style memory bus of the MIPS CPU between two requesters: instruction fetch (port i_*) and data load/store (port d_*).
- Arbitrates between the two, then issues one bus transaction at a time and holds it through waitrequest.
- Captures read data and returns a one-cycle completion pulse to the granted requester.
- Sits between the CPU core and the external bus ports address/read/write/writedata/byteenable/waitrequest/readdata.

Parameters:
TIMEOUT, 256, cycles of continuous waitrequest before a transaction is aborted with err; 0 disables the timeout.
CNT_W, 9, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  single clock; all state updates on its rising edge
reset  in  1  synchronous reset, active-low
i_req  in  1  fetch request, level; held until i_done
i_addr  in  32  fetch byte address
i_rdata  out  32  fetched word; valid while i_done=1, held until the next fetch capture
i_done  out  1  one-cycle fetch completion pulse
d_req  in  1  data request, level; held until d_done
d_we  in  1  1 = store, 0 = load
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_byteenable  in  4  byte lanes for the load/store
d_rdata  out  32  load data; valid while d_done=1, held until the next load capture
d_done  out  1  one-cycle data completion pulse
address  out  32  bus address
read  out  1  bus read strobe
write  out  1  bus write strobe
writedata  out  32  bus write data
byteenable  out  4  bus byte lanes
waitrequest  in  1  slave stall
readdata  in  32  bus read data, valid one cycle after read is accepted
err  out  1  one-cycle pulse, coincident with the done pulse, when a transaction timed out
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset (reset=0 at a clock edge):
  - state goes to IDLE.
  - address, writedata, byteenable, read, write, i_rdata, d_rdata, i_done, d_done, err and busy are all 0.
  - last_grant is set to DATA, so the fetch port wins the first tie.
  - A reset in any state abandons the transaction; strobes are 0 from the next cycle.
- State IDLE:
  - Only i_req set: grant I. Only d_req set: grant D. Both set: grant the port not equal to last_grant (round-robin).
  - On grant: latch address and payload into output registers, set last_grant, go to BUS.
  - Fetch transactions use read=1 and byteenable=4'hF.
  - Data transactions use read=!d_we, write=d_we, writedata=d_wdata, byteenable=d_byteenable.
  - All bus outputs are 0 while in IDLE.
- State BUS:
  - Strobes and payload are held stable.
  - waitrequest=0: the transaction is accepted at this edge. Writes go to DONE; reads go to RDATA. Strobes drop to 0.
  - waitrequest=1: the timeout counter increments.
  - Counter reaches TIMEOUT (TIMEOUT≠0): drop the strobes, set the err flag, go to DONE.
  - The counter clears on entry to BUS.
- State RDATA:
  - Capture readdata into i_rdata or d_rdata, according to the granted port.
  - Go to DONE.
- State DONE:
  - The granted port's done is 1 for exactly this cycle; err=1 in this cycle if the transaction timed out.
  - A timed-out read loads 0 into the rdata output.
  - Go to IDLE. No re-arbitration happens in DONE, so the requester can drop or change its request.
- Latency:
  - Zero-wait read: request seen in IDLE at edge n; BUS during cycle n+1; RDATA n+2; done=1 during n+3.
  - Zero-wait write: done=1 during n+2.
  - Each waitrequest cycle adds 1 to either latency.
- Back-to-back: a request still high in the cycle after DONE is arbitrated normally. Two continuously requesting ports therefore alternate I, D, I, D.
- Protocol rules:
  - i_done and d_done are never high together.
  - read and write are never high together.
  - The arbiter never changes the bus outputs while waitrequest=1.
- Requester rule: a requester that drops req before its done is ignored. The latched transaction still completes and its done pulse is still issued.
- Addresses are passed through unmodified. No alignment checking is done; the slave owns address decoding.

Decomposition:
- Package mips_bus_pkg holds:
  - state enum: IDLE, BUS, RDATA, DONE
  - port-select enum: PORT_I, PORT_D
  - constant BE_WORD = 4'hF
  - reset vector constant 32'hBFC00000, for the benches
- One natural sub-module, mips_bus_rr_pick: combinational two-way round-robin choice from (i_req, d_req, last_grant).
- Everything else lives in mips_bus_arbiter.

Test Plan:
- Reset: hold reset=0 for 3 cycles with both reqs high → all outputs 0. After release, the first grant is fetch with address=i_addr=32'hBFC00000, read=1, byteenable=4'hF.
- Zero-wait fetch: i_req=1, i_addr=32'hBFC00004, memory word 32'h0C000003 → i_done exactly 3 cycles after the grant edge, i_rdata=32'h0C000003, d_done stays 0.
- Store with waitrequest=1 for 4 cycles: d_we=1, d_addr=32'hBFC00100, d_wdata=32'hDEADBEEF, d_byteenable=4'b0011 → write/address/writedata held stable for 5 cycles, one d_done, memory word reads 32'h0000BEEF.
- Contention: i_req and d_req both held high for 6 transactions → grant order I, D, I, D, I, D; never two done pulses in one cycle.
- Timeout: TIMEOUT=8, waitrequest stuck at 1 on a load → read drops after 8 stall cycles; d_done=1 and err=1 in the same cycle; d_rdata=0; next request is served normally.
- Reset mid-transaction: assert reset=0 while in BUS with waitrequest=1 → read=0 next cycle, busy=0, no done pulse; the post-reset first grant goes to fetch.
